// File: rtl/sort_pkg.sv
// Shared types and sizing for the bit-sorter readout path.
// Also provides the thermometer mask helper used for bubble detection.
package sort_pkg;

  localparam int SAMPLES = 2;
  localparam int OSF     = 8;
  localparam int N       = SAMPLES * OSF;
  localparam int CW      = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    SORT,
    DECODE,
    HOLD
  } state_t;

  // Returns 2^c - 1 as an N-bit word; c == N gives all ones.
  function automatic logic [N-1:0] therm_mask(input logic [CW-1:0] c);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      m[i] = (i < int'(c));
    end
    return m;
  endfunction

endpackage

// File: rtl/therm_popcount.sv
// Population count of a sorted word plus a flag for non-thermometer patterns.
// Purely combinational so other sorter consumers can reuse it.
module therm_popcount
  import sort_pkg::*;
(
  input  logic [N-1:0]  word,
  output logic [CW-1:0] count,
  output logic          bubble
);

  logic [CW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) begin
      acc = acc + CW'(word[i]);
    end
    count  = acc;
    bubble = (word != therm_mask(acc));
  end

endmodule

// File: rtl/sort_readout_ctrl.sv
// Sequences sorter precharge/sort, captures the sorted word and presents
// its population count and bubble flag on a valid/ready interface.
//
// state     | meaning
// IDLE      | waiting for start, sorter held in precharge
// PRECHARGE | sort_p high for PRECHARGE_CYCLES
// SORT      | sort_p low for SORT_CYCLES, word captured on the last edge
// DECODE    | popcount/bubble of captured word registered
// HOLD      | result offered until out_ready
module sort_readout_ctrl
  import sort_pkg::*;
#(
  parameter int PRECHARGE_CYCLES = 2,
  parameter int SORT_CYCLES      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          sort_p,
  input  logic [N-1:0]  therm_in,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          bubble_err,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int MAXC = (PRECHARGE_CYCLES > SORT_CYCLES) ? PRECHARGE_CYCLES : SORT_CYCLES;
  localparam int CNTW = $clog2(MAXC + 1);
  localparam logic [CNTW-1:0] PRE_LOAD  = CNTW'(PRECHARGE_CYCLES - 1);
  localparam logic [CNTW-1:0] SORT_LOAD = CNTW'(SORT_CYCLES - 1);

  state_t          state_r, state_nxt;
  logic [CNTW-1:0] cnt_r, cnt_nxt;
  logic [N-1:0]    cap_r;
  logic            capture;
  logic [CW-1:0]   pc_count;
  logic            pc_bubble;

  therm_popcount u_popcount (
    .word   (cap_r),
    .count  (pc_count),
    .bubble (pc_bubble)
  );

  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = (cnt_r != '0) ? cnt_r - 1'b1 : '0;
    capture   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt = PRECHARGE;
          cnt_nxt   = PRE_LOAD;
        end
      end
      PRECHARGE: begin
        if (cnt_r == '0) begin
          state_nxt = SORT;
          cnt_nxt   = SORT_LOAD;
        end
      end
      SORT: begin
        if (cnt_r == '0) begin
          state_nxt = DECODE;
          cnt_nxt   = '0;
          capture   = 1'b1;
        end
      end
      DECODE: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
      HOLD: begin
        // out_valid is high exactly in HOLD, so out_ready alone completes the handshake
        if (out_ready) begin
          state_nxt = start ? PRECHARGE : IDLE;
          cnt_nxt   = start ? PRE_LOAD : '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      cap_r      <= '0;
      count      <= '0;
      bubble_err <= 1'b0;
      sort_p     <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      if (capture) begin
        cap_r <= therm_in;
      end
      if (state_r == DECODE) begin
        count      <= pc_count;
        bubble_err <= pc_bubble;
      end
      // outputs follow the next state so they line up with the state register
      sort_p    <= (state_nxt != SORT);
      busy      <= (state_nxt != IDLE);
      out_valid <= (state_nxt == HOLD);
    end
  end

endmodule

// File: tb/tb_sort_readout_ctrl.sv
// Directed bench for sort_readout_ctrl with a result scoreboard.
module tb_sort_readout_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sort_p;
  logic [15:0] therm_in;
  logic        busy;
  logic [4:0]  count;
  logic        bubble_err;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  logic [5:0] sb_q[$];
  logic [5:0] exp_v;

  sort_readout_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sort_p     (sort_p),
    .therm_in   (therm_in),
    .busy       (busy),
    .count      (count),
    .bubble_err (bubble_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {count, bubble}: independent bit count and 2^c-1 compare.
  function automatic logic [5:0] model(input logic [15:0] w);
    int c;
    logic b;
    c = 0;
    for (int i = 0; i < 16; i++) if (w[i]) c++;
    b = ({16'd0, w} != ((32'd1 << c) - 32'd1));
    return {c[4:0], b};
  endfunction

  task automatic pop_check(input string tag);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp_v = sb_q.pop_front();
      chk({tag, "_count"}, {27'd0, count}, {27'd0, exp_v[5:1]});
      chk({tag, "_bubble"}, {31'd0, bubble_err}, {31'd0, exp_v[0]});
    end
  endtask

  // One conversion from IDLE; glitch drives junk before and after the capture edge.
  task automatic convert(input string tag, input logic [15:0] w, input bit glitch);
    int lat, hi_pre, lo;
    bit seen_low, busy_drop;
    therm_in = glitch ? 16'h5A5A : w;
    start    = 1'b1;
    tick();
    start = 1'b0;
    sb_q.push_back(model(w));
    lat = 0; hi_pre = 0; lo = 0; seen_low = 0; busy_drop = 0;
    while (!out_valid && lat < 20) begin
      if (sort_p === 1'b0) begin
        lo++;
        seen_low = 1;
      end else if (!seen_low) begin
        hi_pre++;
      end
      if (busy !== 1'b1) busy_drop = 1;
      if (glitch && lat == 0) therm_in = w;
      if (glitch && lat == 6) therm_in = 16'hFFFF;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 7);
    chk({tag, "_pre_cycles"}, hi_pre, 2);
    chk({tag, "_sort_cycles"}, lo, 4);
    chk({tag, "_busy_held"}, {31'd0, busy_drop}, 0);
    pop_check(tag);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 0);
    chk({tag, "_idle"}, {31'd0, busy}, 0);
  endtask

  initial begin
    logic [4:0] held_count;
    logic       held_bubble;
    int lat;
    bit glitch_valid;

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; therm_in = 16'h0000;

    // 1. reset
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_sort_p", {31'd0, sort_p}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_count", {27'd0, count}, 0);
    chk("rst_bubble", {31'd0, bubble_err}, 0);
    therm_in = 16'h1234;
    tick(); tick(); tick();
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_sort_p", {31'd0, sort_p}, 1);

    // 2-4. single conversions
    convert("w00ff", 16'h00FF, 1'b0); accept("w00ff");
    convert("w0000", 16'h0000, 1'b0); accept("w0000");
    convert("wffff", 16'hFFFF, 1'b0); accept("wffff");
    convert("w00f7", 16'h00F7, 1'b1); accept("w00f7");
    convert("w8001", 16'h8001, 1'b0); accept("w8001");

    // 5. backpressure, ignored starts, back-to-back
    convert("bp1", 16'h0007, 1'b0);
    held_count  = count;
    held_bubble = bubble_err;
    therm_in    = 16'h0FFF;
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      tick();
      chk("bp_valid", {31'd0, out_valid}, 1);
      chk("bp_count", {27'd0, count}, {27'd0, held_count});
      chk("bp_bubble", {31'd0, bubble_err}, {31'd0, held_bubble});
    end
    start = 1'b1;
    out_ready = 1'b1;
    sb_q.push_back(model(16'h0FFF));
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    chk("b2b_valid_drop", {31'd0, out_valid}, 0);
    chk("b2b_busy", {31'd0, busy}, 1);
    chk("b2b_sort_p", {31'd0, sort_p}, 1);
    chk("b2b_old_count", {27'd0, count}, {27'd0, held_count});
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (busy !== 1'b1) chk("b2b_busy_gap", {31'd0, busy}, 1);
      tick();
      lat++;
    end
    chk("b2b_latency", lat, 7);
    pop_check("b2b");
    accept("b2b");

    // 6. reset in the second SORT cycle
    therm_in = 16'h00FF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mid_in_sort", {31'd0, sort_p}, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_sort_p", {31'd0, sort_p}, 1);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_count", {27'd0, count}, 0);
    glitch_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) glitch_valid = 1;
    end
    chk("mid_rst_quiet", {31'd0, glitch_valid}, 0);
    convert("post_rst", 16'h003F, 1'b0);
    accept("post_rst");

    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
